// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/ack into a 2-deep queue, handles jump flush and debug halt/step
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          INSTR_W  = 40
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_mem_req,
    output logic [31:0]        o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_data,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [31:0]        o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_jump,
    input  logic [31:0]        i_jump_target,
    input  logic               i_halt,
    input  logic               i_step,
    output logic               o_halted
);
    logic [31:0]        fpc, base;
    logic [INSTR_W-1:0] q_data [2];
    logic [31:0]        q_pc [2];
    logic [1:0]         cnt, cnt_n;
    logic               rd, wi, credit, credit_n, discard, discard_n;
    logic               ack, hs, push, busy, issue, halted_n;

    always_comb begin
        o_instr_valid = (cnt != 2'd0) && (!i_halt || credit);
        o_instr       = q_data[rd];
        o_instr_pc    = q_pc[rd];
        ack           = o_mem_req && i_mem_ack;
        hs            = o_instr_valid && i_instr_ready;
        push          = ack && !discard && !i_jump;
        wi            = rd ^ cnt[0];
        cnt_n         = i_jump ? 2'd0 : cnt + {1'b0, push} - {1'b0, hs};
        credit_n      = credit ? !hs : (i_step && o_halted);
        busy          = o_mem_req && !ack;
        discard_n     = busy && (discard || i_jump);
        issue         = !busy && (cnt_n < 2'd2) && (!i_halt || (credit_n && cnt_n == 2'd0));
        base          = i_jump ? i_jump_target : fpc;
        halted_n      = i_halt && !(busy || issue);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_req  <= 1'b0;
            o_mem_addr <= RESET_PC;
            o_halted   <= 1'b0;
            fpc        <= RESET_PC;
            cnt        <= 2'd0;
            rd         <= 1'b0;
            credit     <= 1'b0;
            discard    <= 1'b0;
            q_data[0]  <= '0;
            q_data[1]  <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
        end else begin
            o_mem_req <= busy || issue;
            o_halted  <= halted_n;
            cnt       <= cnt_n;
            rd        <= rd ^ hs;
            credit    <= credit_n;
            discard   <= discard_n;
            fpc       <= issue ? base + 32'd1 : base;
            if (issue)
                o_mem_addr <= base;
            if (push) begin
                q_data[wi] <= i_mem_data;
                q_pc[wi]   <= o_mem_addr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch order, backpressure, jumps, halt/step, wrap and reset
module tb_fetch_sequencer;
    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_mem_ack;
    logic [39:0] i_mem_data;
    logic        i_instr_ready = 1'b0, i_jump = 1'b0, i_halt = 1'b0, i_step = 1'b0;
    logic [31:0] i_jump_target = '0;
    logic        o_mem_req, o_instr_valid, o_halted;
    logic [31:0] o_mem_addr, o_instr_pc;
    logic [39:0] o_instr;

    fetch_sequencer #(.RESET_PC(32'd0), .INSTR_W(40)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_ready(i_instr_ready),
        .i_jump(i_jump), .i_jump_target(i_jump_target),
        .i_halt(i_halt), .i_step(i_step), .o_halted(o_halted)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_bad = 0;

    function automatic logic [39:0] fmem(input logic [31:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // program memory model with programmable ack latency, or manual ack
    logic        auto_mode = 1'b1, resp_ack = 1'b0, man_ack = 1'b0;
    logic [39:0] resp_data = '0;
    int          lat = 1, w = 0;
    assign i_mem_ack  = auto_mode ? resp_ack : man_ack;
    assign i_mem_data = resp_data;

    always @(posedge i_clk) begin
        #1;
        if (!auto_mode) begin
            w = 0;
            resp_ack = 1'b0;
        end else begin
            if (!o_mem_req || resp_ack) w = 0;
            if (o_mem_req) w++;
            resp_ack = o_mem_req && (w >= lat);
        end
        resp_data = fmem(o_mem_addr);
    end

    logic [31:0] d_pc [256];
    logic [39:0] d_dat [256];
    logic [31:0] a_addr [256];
    int dn = 0, an = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            d_pc[i] = 32'hDEAD_BEEF;
            d_dat[i] = '1;
            a_addr[i] = 32'hDEAD_BEEF;
        end
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_instr_valid && i_instr_ready && dn < 256) begin
                d_pc[dn] = o_instr_pc;
                d_dat[dn] = o_instr;
                dn++;
            end
            if (!i_rst && o_mem_req && i_mem_ack && an < 256) begin
                a_addr[an] = o_mem_addr;
                an++;
            end
        end
    end

    function automatic logic [31:0] dpc(input int i);
        return (i < dn) ? d_pc[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [39:0] ddat(input int i);
        return (i < dn) ? d_dat[i] : '1;
    endfunction
    function automatic logic [31:0] apc(input int i);
        return (i < an) ? a_addr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        i_rst = 1'b1;
        tick(2);
        i_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int d0, a0;

    initial begin
        repeat (2) @(negedge i_clk);
        chk("rst_req", o_mem_req, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_valid", o_instr_valid, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_pc", o_instr_pc, 0);
        chk("rst_halted", o_halted, 0);

        // straight-line fetch, ready high
        i_instr_ready = 1'b1;
        lat = 1;
        tick(1);
        i_rst = 1'b0;
        d0 = dn; a0 = an;
        tick(14);
        for (int k = 0; k < 4; k++) chk($sformatf("seq_addr%0d", k), apc(a0 + k), k);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("seq_pc%0d", k), dpc(d0 + k), k);
            chk($sformatf("seq_dat%0d", k), ddat(d0 + k), fmem(k));
        end

        // backpressure: queue fills to two, then drains in order
        i_instr_ready = 1'b0;
        do_reset();
        a0 = an; d0 = dn;
        tick(10);
        @(negedge i_clk);
        chk("bp_valid", o_instr_valid, 1);
        chk("bp_head_pc", o_instr_pc, 0);
        chk("bp_req_idle", o_mem_req, 0);
        chk("bp_fetched", an - a0, 2);
        tick(1);
        i_instr_ready = 1'b1;
        tick(10);
        for (int k = 0; k < 4; k++) chk($sformatf("bp_pc%0d", k), dpc(d0 + k), k);

        // jump while the fetch of addr 5 is still outstanding
        lat = 3;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (o_mem_req && o_mem_addr == 32'd5) break;
        end
        chk("jmp_find5", o_mem_addr, 5);
        tick(1);
        i_jump = 1'b1; i_jump_target = 32'h40;
        a0 = an;
        tick(1);
        i_jump = 1'b0;
        @(negedge i_clk);
        chk("jmp_flushed", o_instr_valid, 0);
        tick(1);
        d0 = dn;
        tick(20);
        chk("jmp_ack5", apc(a0), 5);
        chk("jmp_next_addr", apc(a0 + 1), 32'h40);
        chk("jmp_first_pc", dpc(d0), 32'h40);
        chk("jmp_first_dat", ddat(d0), fmem(32'h40));

        // jump coincident with handshake of pc 7, pc 8 queued behind it
        lat = 1;
        i_instr_ready = 1'b0;
        do_reset();
        tick(1);
        i_jump = 1'b1; i_jump_target = 32'd7;
        tick(1);
        i_jump = 1'b0;
        tick(8);
        @(negedge i_clk);
        chk("jhs_head7", o_instr_pc, 7);
        chk("jhs_valid", o_instr_valid, 1);
        tick(1);
        d0 = dn;
        i_instr_ready = 1'b1; i_jump = 1'b1; i_jump_target = 32'h20;
        tick(1);
        i_jump = 1'b0;
        tick(8);
        chk("jhs_took7", dpc(d0), 7);
        chk("jhs_next", dpc(d0 + 1), 32'h20);
        chk("jhs_next_dat", ddat(d0 + 1), fmem(32'h20));

        // halt mid-stream, then release
        lat = 2;
        do_reset();
        tick(5);
        i_halt = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_halted) break;
        end
        chk("halt_reached", o_halted, 1);
        chk("halt_valid", o_instr_valid, 0);
        chk("halt_req", o_mem_req, 0);
        tick(1);
        i_halt = 1'b0;
        @(negedge i_clk);
        chk("unhalt_lag", o_halted, 1);
        @(negedge i_clk);
        chk("unhalt_clear", o_halted, 0);

        // halted from reset, three single steps
        lat = 1;
        tick(1);
        i_halt = 1'b1;
        do_reset();
        d0 = dn;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 20; k++) begin
                @(negedge i_clk);
                if (o_halted) break;
            end
            chk($sformatf("step%0d_halted", s), o_halted, 1);
            tick(1);
            i_step = 1'b1;
            tick(1);
            i_step = 1'b0;
            tick(6);
        end
        @(negedge i_clk);
        chk("step_rehalted", o_halted, 1);
        chk("step_valid", o_instr_valid, 0);
        chk("step_count", dn - d0, 3);
        for (int k = 0; k < 3; k++) chk($sformatf("step_pc%0d", k), dpc(d0 + k), k);
        tick(1);
        i_halt = 1'b0;

        // PC wrap
        do_reset();
        tick(3);
        i_jump = 1'b1; i_jump_target = 32'hFFFF_FFFF;
        tick(1);
        i_jump = 1'b0;
        tick(1);
        d0 = dn;
        tick(8);
        chk("wrap_top", dpc(d0), 32'hFFFF_FFFF);
        chk("wrap_zero", dpc(d0 + 1), 0);
        chk("wrap_dat", ddat(d0 + 1), fmem(0));

        // reset while a fetch is pending, stale ack afterwards
        lat = 100;
        do_reset();
        tick(1);
        @(negedge i_clk);
        chk("rw_req", o_mem_req, 1);
        chk("rw_addr", o_mem_addr, 0);
        tick(1);
        auto_mode = 1'b0; man_ack = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("rw_async_req", o_mem_req, 0);
        d0 = dn;
        tick(1);
        i_rst = 1'b0; man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0; lat = 1; auto_mode = 1'b1;
        @(negedge i_clk);
        chk("rw_stale_valid", o_instr_valid, 0);
        chk("rw_restart_req", o_mem_req, 1);
        chk("rw_restart_addr", o_mem_addr, 0);
        tick(6);
        chk("rw_pc0", dpc(d0), 0);
        chk("rw_dat0", ddat(d0), fmem(0));
        chk("rw_pc1", dpc(d0 + 1), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
